// File: rtl/freq_meter_pkg.sv
// Shared definitions for the cymometer measurement cores: default sizes, FSM encoding
// and the gate-length helper.
package freq_meter_pkg;

  localparam int CNT_W_DEF  = 30;
  localparam int CLK_HZ_DEF = 50_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    GATE  = 2'd2
  } fgc_state_t;

  function automatic int gate_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input plus a registered one-cycle
// rising-edge pulse; edge-to-pulse latency is SYNC_STAGES+1 clock cycles.
module sig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Gated-window frequency counter: counts sig_in rising edges over GATE_CYCLES sys_clk
// cycles and publishes the count in Hz. Optional short window: define FGC_GATE_SEL_EN.
module freq_gate_counter
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int GATE_MS     = 1000,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic             hold,
`ifdef FGC_GATE_SEL_EN
  input  logic             gate_sel,
`endif
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy,
  output fgc_state_t       state
);

  // freq_valid is a single-cycle strobe with no ready/backpressure: a consumer must
  // capture freq_out/ovf in the cycle freq_valid is high.

  localparam int GATE_CYCLES = gate_cycles(CLK_HZ, GATE_MS);
  localparam int GC_MAX      = (GATE_CYCLES > SYNC_STAGES + 1) ? GATE_CYCLES : SYNC_STAGES + 1;
  localparam int GC_W        = $clog2(GC_MAX);
  localparam logic [GC_W-1:0]  TERM_FULL  = GC_W'(GATE_CYCLES - 1);
  localparam logic [GC_W-1:0]  FLUSH_LAST = GC_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             edge_p;
  logic [GC_W-1:0]  gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             edge_sat;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;
  logic [CNT_W-1:0] res;
  logic             res_sat;
  logic [GC_W-1:0]  term_val;
  logic             term;

  sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .sig  (sig_in),
    .rise (edge_p)
  );

  // Saturating increment; edge_sat remembers that at least one edge was dropped.
  always_comb begin
    cnt_next = edge_cnt;
    sat_next = edge_sat;
    if (edge_p) begin
      if (edge_cnt == CNT_MAX) sat_next = 1'b1;
      else                     cnt_next = edge_cnt + CNT_W'(1);
    end
  end

`ifdef FGC_GATE_SEL_EN
  localparam int SHORT_CYCLES = (GATE_CYCLES >= 10) ? GATE_CYCLES / 10 : 1;
  localparam logic [GC_W-1:0] TERM_SHORT = GC_W'(SHORT_CYCLES - 1);

  logic             win_short;
  logic [CNT_W+3:0] scaled;

  always_comb begin
    scaled  = ({4'b0, cnt_next} << 3) + ({4'b0, cnt_next} << 1);
    res     = cnt_next;
    res_sat = sat_next;
    if (win_short) begin
      if (scaled > {4'b0, CNT_MAX}) begin
        res     = CNT_MAX;
        res_sat = 1'b1;
      end else begin
        res = scaled[CNT_W-1:0];
      end
    end
  end

  assign term_val = win_short ? TERM_SHORT : TERM_FULL;

  // Window length is latched only when a window begins.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en)
      win_short <= 1'b0;
    else if ((state == FLUSH && gate_cnt == FLUSH_LAST) || (state == GATE && term))
      win_short <= gate_sel;
  end
`else
  assign res      = cnt_next;
  assign res_sat  = sat_next;
  assign term_val = TERM_FULL;
`endif

  assign term = (gate_cnt == term_val);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      edge_sat   <= 1'b0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        gate_cnt <= '0;
        edge_cnt <= '0;
        edge_sat <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= FLUSH;
            gate_cnt <= '0;
          end
          FLUSH: begin
            // gate_cnt doubles as the flush timer so stale synchroniser bits are ignored.
            if (gate_cnt == FLUSH_LAST) begin
              state    <= GATE;
              busy     <= 1'b1;
              gate_cnt <= '0;
              edge_cnt <= '0;
              edge_sat <= 1'b0;
            end else begin
              gate_cnt <= gate_cnt + GC_W'(1);
            end
          end
          GATE: begin
            if (term) begin
              gate_cnt   <= '0;
              edge_cnt   <= '0;
              edge_sat   <= 1'b0;
              freq_valid <= 1'b1;
              if (!hold) begin
                freq_out <= res;
                ovf      <= res_sat;
              end
            end else begin
              gate_cnt <= gate_cnt + GC_W'(1);
              edge_cnt <= cnt_next;
              edge_sat <= sat_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter with CLK_HZ=1000, GATE_MS=100, CNT_W=5; expected
// window results are queued by the stimulus and popped by a monitor on each freq_valid.
module tb_freq_gate_counter;
  import freq_meter_pkg::*;

  localparam int CNT_W = 5;
  localparam int W     = CNT_W + 1;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             en;
  logic             sig_in;
  logic             hold;
`ifdef FGC_GATE_SEL_EN
  logic             gate_sel;
`endif
  logic [CNT_W-1:0] freq_out;
  logic             freq_valid;
  logic             ovf;
  logic             busy;
  fgc_state_t       state;

  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int gen_p       = 0;

  // clock / reset
  always #10 sys_clk = ~sys_clk;

  freq_gate_counter #(
    .CLK_HZ      (1000),
    .GATE_MS     (100),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .sig_in     (sig_in),
    .hold       (hold),
`ifdef FGC_GATE_SEL_EN
    .gate_sel   (gate_sel),
`endif
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .ovf        (ovf),
    .busy       (busy),
    .state      (state)
  );

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_win(input logic o, input logic [CNT_W-1:0] f);
    exp_q.push_back({o, f});
  endtask

  task automatic set_pattern(input int p);
    en    = 1'b0;
    gen_p = p;
    cycles(p + 10);
    if (p == 0) sig_in = 1'b0;
    cycles(5);
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!freq_valid && n < bound);
  endtask

  // periodic sig_in generator: period gen_p cycles, 0 = idle (stimulus drives sig_in)
  initial begin : sig_gen
    int ph;
    int last_p;
    ph = 0;
    last_p = 0;
    forever begin
      @(negedge sys_clk);
      if (gen_p != last_p) begin
        ph = 0;
        last_p = gen_p;
      end
      if (gen_p != 0) begin
        sig_in = (ph < gen_p / 2);
        ph = (ph + 1) % gen_p;
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic [W-1:0] exp;
    forever begin
      @(negedge sys_clk);
      if (freq_valid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: got freq_out=%0d ovf=%0d, expected no publish",
                   freq_out, ovf);
        end else begin
          exp = exp_q.pop_front();
          if ({ovf, freq_out} !== exp) begin
            miscompares++;
            $display("FAIL window_result: got ovf=%0d freq_out=%0d, expected ovf=%0d freq_out=%0d",
                     ovf, freq_out, exp[W-1], exp[CNT_W-1:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(20 * 20000);
    miscompares++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n;
    int cur;
    int offs[5];
    offs = '{30, 100, 150, 201, 250};
    sys_rst = 1'b1;
    en      = 1'b0;
    sig_in  = 1'b0;
    hold    = 1'b0;
`ifdef FGC_GATE_SEL_EN
    gate_sel = 1'b0;
`endif
    cycles(3);
    check("rst_freq_out", freq_out, 0);
    check("rst_freq_valid", freq_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state, IDLE);
    sys_rst = 1'b0;
    cycles(2);

    // period 10 -> 10 Hz per window, repeating
    set_pattern(10);
    expect_win(1'b0, 5'd10);
    expect_win(1'b0, 5'd10);
    en = 1'b1;
    cycles(4);
    check("t1_busy_gate", busy, 1);
    cycles(206);
    en = 1'b0;
    cycles(2);
    check("t1_drain", exp_q.size(), 0);

    // max rate saturates a 5-bit counter, then a slow signal clears ovf
    set_pattern(2);
    expect_win(1'b1, 5'd31);
    en = 1'b1;
    cycles(110);
    check("t2_sat_out", freq_out, 31);
    set_pattern(50);
    expect_win(1'b0, 5'd2);
    en = 1'b1;
    cycles(110);
    en = 1'b0;
    cycles(2);
    check("t2_drain", exp_q.size(), 0);

    // hold across a publish keeps the old value; next window updates
    set_pattern(10);
    hold = 1'b1;
    expect_win(1'b0, 5'd2);
    expect_win(1'b0, 5'd10);
    en = 1'b1;
    cycles(110);
    check("t5_held", freq_out, 2);
    hold = 1'b0;
    cycles(100);
    check("t5_released", freq_out, 10);
    en = 1'b0;
    cycles(2);
    check("t5_drain", exp_q.size(), 0);

    // abort at gate_cnt=50, then restart with a new window
    set_pattern(20);
    expect_win(1'b0, 5'd5);
    en = 1'b1;
    cycles(154);
    en = 1'b0;
    cycles(1);
    check("t4_busy_off", busy, 0);
    check("t4_state_idle", state, IDLE);
    check("t4_freq_kept", freq_out, 5);
    gen_p = 25;
    cycles(40);
    expect_win(1'b0, 5'd4);
    en = 1'b1;
    cycles(1);
    check("t4_state_flush", state, FLUSH);
    check("t4_busy_flush", busy, 0);
    cycles(3);
    check("t4_state_gate", state, GATE);
    cycles(106);
    en = 1'b0;
    cycles(2);
    check("t4_drain", exp_q.size(), 0);

    // single edges on a terminal cycle and on a first cycle are counted once each
    set_pattern(0);
    expect_win(1'b0, 5'd2);
    expect_win(1'b0, 5'd1);
    expect_win(1'b0, 5'd2);
    en = 1'b1;
    cur = 0;
    foreach (offs[i]) begin
      cycles(offs[i] - cur);
      sig_in = 1'b1;
      cycles(1);
      sig_in = 1'b0;
      cur = offs[i] + 1;
    end
    cycles(310 - cur);
    en = 1'b0;
    cycles(2);
    check("t3_drain", exp_q.size(), 0);

    // synchronous reset mid-window
    set_pattern(10);
    en = 1'b1;
    cycles(60);
    sys_rst = 1'b1;
    cycles(1);
    check("mrst_freq_out", freq_out, 0);
    check("mrst_valid", freq_valid, 0);
    check("mrst_ovf", ovf, 0);
    check("mrst_busy", busy, 0);
    check("mrst_state", state, IDLE);
    sys_rst = 1'b0;
    en = 1'b0;
    cycles(120);
    check("mrst_drain", exp_q.size(), 0);

`ifdef FGC_GATE_SEL_EN
    // short window x10 scaling; mid-window gate_sel change waits for the next window
    set_pattern(5);
    gate_sel = 1'b1;
    expect_win(1'b0, 5'd20);
    expect_win(1'b0, 5'd20);
    expect_win(1'b0, 5'd20);
    en = 1'b1;
    cycles(18);
    gate_sel = 1'b0;
    wait_valid(50, n);
    check("t6_short_gap", n, 6);
    wait_valid(200, n);
    check("t6_long_gap", n, 100);
    en = 1'b0;
    cycles(2);
    check("t6_drain", exp_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
